// File: rtl/exc_seq.sv
// Exception sequencer: latches the winning exception cause and faulting PC, reads the
// handler byte from the cause's vector address, then strobes EPC and PC writes in turn.
module exc_seq #(
    parameter int VEC_OPCODE = 253,
    parameter int VEC_OVF    = 254,
    parameter int VEC_DIVZ   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_divz,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc_out,
    output logic        epc_we,
    output logic [31:0] pc_out,
    output logic        pc_we,
    output logic [1:0]  cause,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic [2:0]  state_dbg
);

    localparam logic [31:0] ADDR_OPCODE = 32'(VEC_OPCODE);
    localparam logic [31:0] ADDR_OVF    = 32'(VEC_OVF);
    localparam logic [31:0] ADDR_DIVZ   = 32'(VEC_DIVZ);

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_OPCODE = 2'd1;
    localparam logic [1:0] CAUSE_OVF    = 2'd2;
    localparam logic [1:0] CAUSE_DIVZ   = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        FETCH3 = 3'd3,
        COMMIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    logic        any_event;
    logic [1:0]  win_cause;
    logic [31:0] win_vec;

    // Only the vector byte matters; upper bytes of the memory word are ignored.
    logic        unused_rdata;
    assign unused_rdata = ^mem_rdata[31:8];

    assign state_dbg = state;
    assign any_event = exc_opcode | exc_ovf | exc_divz;

    // Fixed priority: opcode beats overflow beats divide-by-zero.
    always_comb begin
        win_cause = CAUSE_NONE;
        win_vec   = '0;
        if (exc_opcode) begin
            win_cause = CAUSE_OPCODE;
            win_vec   = ADDR_OPCODE;
        end else if (exc_ovf) begin
            win_cause = CAUSE_OVF;
            win_vec   = ADDR_OVF;
        end else if (exc_divz) begin
            win_cause = CAUSE_DIVZ;
            win_vec   = ADDR_DIVZ;
        end
    end

    // Outputs are registered alongside the state so each one is a pure function
    // of the state being entered; strobes default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            epc_out  <= '0;
            epc_we   <= 1'b0;
            pc_out   <= '0;
            pc_we    <= 1'b0;
            cause    <= CAUSE_NONE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            epc_we <= 1'b0;
            pc_we  <= 1'b0;
            done   <= 1'b0;

            if (state != IDLE && any_event) begin
                dropped <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (any_event) begin
                        state    <= FETCH1;
                        cause    <= win_cause;
                        epc_out  <= pc_in - 32'd4;
                        epc_we   <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= win_vec;
                        busy     <= 1'b1;
                    end
                end
                FETCH1: state <= FETCH2;
                FETCH2: state <= FETCH3;
                FETCH3: begin
                    // Memory/MDR path has had two cycles; the vector byte is valid now.
                    state    <= COMMIT;
                    pc_out   <= {24'b0, mem_rdata[7:0]};
                    pc_we    <= 1'b1;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end
                COMMIT: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: scenario tasks drive exception flows against a vector memory
// model; expected EPC/PC/cause values are queued at stimulus and popped at the strobes.
module tb_exc_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_ovf = 1'b0;
    logic        exc_divz = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] epc_out;
    logic        epc_we;
    logic [31:0] pc_out;
    logic        pc_we;
    logic [1:0]  cause;
    logic        busy;
    logic        done;
    logic        dropped;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] vec_mem [256];
    logic [31:0] exp_epc_q[$];
    logic [31:0] exp_pc_q[$];
    logic [1:0]  exp_cause_q[$];

    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? vec_mem[mem_addr[7:0]] : 32'h5A5A_5A5A;

    exc_seq dut (
        .clk        (clk),
        .reset      (reset),
        .exc_opcode (exc_opcode),
        .exc_ovf    (exc_ovf),
        .exc_divz   (exc_divz),
        .pc_in      (pc_in),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .epc_out    (epc_out),
        .epc_we     (epc_we),
        .pc_out     (pc_out),
        .pc_we      (pc_we),
        .cause      (cause),
        .busy       (busy),
        .done       (done),
        .dropped    (dropped),
        .state_dbg  (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ev = {opcode, overflow, divz}
    task automatic set_ev(input logic [2:0] ev);
        exc_opcode = ev[2];
        exc_ovf    = ev[1];
        exc_divz   = ev[0];
    endtask

    function automatic logic [1:0] prio(input logic [2:0] ev);
        if (ev[2]) return 2'd1;
        if (ev[1]) return 2'd2;
        if (ev[0]) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] vec_of(input logic [1:0] c);
        case (c)
            2'd1:    return 32'd253;
            2'd2:    return 32'd254;
            2'd3:    return 32'd255;
            default: return 32'd0;
        endcase
    endfunction

    // One accepted exception, entered in an IDLE cycle. Events inj_ev are driven
    // during cycles inj_lo..inj_hi (inj_lo = 0: none). Returns in cycle 6 (IDLE).
    task automatic flow(input string name, input logic [2:0] ev, input logic [31:0] pc,
                        input int inj_lo, input int inj_hi, input logic [2:0] inj_ev,
                        input logic drop0);
        logic [1:0]  c_exp;
        logic [31:0] v_exp;
        logic [31:0] e_epc;
        logic [31:0] e_pc;
        logic [1:0]  e_cause;
        logic        d_exp;
        c_exp = prio(ev);
        v_exp = vec_of(c_exp);
        exp_epc_q.push_back(pc - 32'd4);
        exp_pc_q.push_back({24'b0, vec_mem[v_exp[7:0]][7:0]});
        exp_cause_q.push_back(c_exp);
        e_epc   = '0;
        e_pc    = '0;
        e_cause = exp_cause_q.pop_front();
        pc_in = pc;
        set_ev(ev);
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (inj_lo > 0 && c >= inj_lo && c <= inj_hi) set_ev(inj_ev);
            else set_ev(3'b000);
            d_exp = drop0 || (inj_lo > 0 && c > inj_lo);
            if (c == 1) e_epc = exp_epc_q.pop_front();
            if (c == 4) e_pc = exp_pc_q.pop_front();
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s c%0d busy got %b want 1", name, c, busy); end
            n_cmp++; if (epc_we !== (c == 1)) begin n_err++; $display("FAIL %s c%0d epc_we got %b want %b", name, c, epc_we, c == 1); end
            n_cmp++; if (mem_rd !== (c <= 3)) begin n_err++; $display("FAIL %s c%0d mem_rd got %b want %b", name, c, mem_rd, c <= 3); end
            if (c <= 3) begin
                n_cmp++; if (mem_addr !== v_exp) begin n_err++; $display("FAIL %s c%0d mem_addr got %0d want %0d", name, c, mem_addr, v_exp); end
            end
            n_cmp++; if (pc_we !== (c == 4)) begin n_err++; $display("FAIL %s c%0d pc_we got %b want %b", name, c, pc_we, c == 4); end
            n_cmp++; if (done !== (c == 5)) begin n_err++; $display("FAIL %s c%0d done got %b want %b", name, c, done, c == 5); end
            n_cmp++; if (cause !== e_cause) begin n_err++; $display("FAIL %s c%0d cause got %0d want %0d", name, c, cause, e_cause); end
            n_cmp++; if (epc_out !== e_epc) begin n_err++; $display("FAIL %s c%0d epc_out got %h want %h", name, c, epc_out, e_epc); end
            if (c >= 4) begin
                n_cmp++; if (pc_out !== e_pc) begin n_err++; $display("FAIL %s c%0d pc_out got %h want %h", name, c, pc_out, e_pc); end
            end
            n_cmp++; if (dropped !== d_exp) begin n_err++; $display("FAIL %s c%0d dropped got %b want %b", name, c, dropped, d_exp); end
            tick();
        end
        set_ev(3'b000);
        d_exp = drop0 || (inj_lo > 0 && 6 > inj_lo);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s idle busy got %b want 0", name, busy); end
        n_cmp++; if ({epc_we, mem_rd, pc_we, done} !== 4'b0000) begin n_err++; $display("FAIL %s idle strobes got %b want 0000", name, {epc_we, mem_rd, pc_we, done}); end
        n_cmp++; if (cause !== e_cause) begin n_err++; $display("FAIL %s idle cause got %0d want %0d", name, cause, e_cause); end
        n_cmp++; if (epc_out !== e_epc) begin n_err++; $display("FAIL %s idle epc_out got %h want %h", name, epc_out, e_epc); end
        n_cmp++; if (pc_out !== e_pc) begin n_err++; $display("FAIL %s idle pc_out got %h want %h", name, pc_out, e_pc); end
        n_cmp++; if (dropped !== d_exp) begin n_err++; $display("FAIL %s idle dropped got %b want %b", name, dropped, d_exp); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_ev(3'b000);
        tick();
        tick();
        n_cmp++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL reset state got %0d want 0", state_dbg); end
        n_cmp++; if ({mem_addr, epc_out, pc_out} !== 96'd0) begin n_err++; $display("FAIL reset data got %h %h %h want 0", mem_addr, epc_out, pc_out); end
        n_cmp++; if ({cause, dropped, busy, done, mem_rd, epc_we, pc_we} !== 8'd0) begin n_err++; $display("FAIL reset flags got %b want 0", {cause, dropped, busy, done, mem_rd, epc_we, pc_we}); end
        reset = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        vec_mem[254] = 32'h1234_569C;
        flow("overflow", 3'b010, 32'h40, 0, 0, 3'b000, 1'b0);
        n_cmp++; if (pc_out !== 32'h9C) begin n_err++; $display("FAIL overflow_pc got %h want 0000009c", pc_out); end
        n_cmp++; if (epc_out !== 32'h3C) begin n_err++; $display("FAIL overflow_epc got %h want 0000003c", epc_out); end
    endtask

    task automatic test_simultaneous();
        vec_mem[253] = 32'h0000_0077;
        vec_mem[255] = 32'h0000_0011;
        flow("simul", 3'b101, 32'h1000, 0, 0, 3'b000, 1'b0);
    endtask

    task automatic test_wrap();
        vec_mem[253] = 32'hAABB_CCFF;
        flow("wrap", 3'b100, 32'h0, 0, 0, 3'b000, 1'b0);
        n_cmp++; if (epc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_epc got %h want fffffffc", epc_out); end
        n_cmp++; if (pc_out !== 32'h0000_00FF) begin n_err++; $display("FAIL wrap_pc got %h want 000000ff", pc_out); end
    endtask

    task automatic test_drop_midflow();
        vec_mem[255] = 32'h0000_0042;
        vec_mem[254] = 32'h0000_00EE;
        flow("drop_mid", 3'b001, 32'h2000, 2, 2, 3'b010, 1'b0);
    endtask

    task automatic test_reset_mid();
        pc_in = 32'h100;
        set_ev(3'b010);
        tick();
        set_ev(3'b000);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL rst_mid state got %0d want 0", state_dbg); end
        n_cmp++; if ({mem_addr, epc_out, pc_out} !== 96'd0) begin n_err++; $display("FAIL rst_mid data got %h %h %h want 0", mem_addr, epc_out, pc_out); end
        n_cmp++; if ({cause, dropped, busy, done, mem_rd, epc_we, pc_we} !== 8'd0) begin n_err++; $display("FAIL rst_mid flags got %b want 0", {cause, dropped, busy, done, mem_rd, epc_we, pc_we}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({pc_we, busy} !== 2'b00) begin n_err++; $display("FAIL rst_hold%0d pc_we/busy got %b want 00", i, {pc_we, busy}); end
        end
        reset = 1'b1;
        vec_mem[254] = 32'h0000_0033;
        flow("post_reset", 3'b010, 32'h200, 0, 0, 3'b000, 1'b0);
    endtask

    task automatic test_held_through_done();
        vec_mem[254] = 32'h0000_00A5;
        flow("held", 3'b010, 32'h300, 1, 5, 3'b010, 1'b0);
        flow("held_reaccept", 3'b010, 32'h300, 0, 0, 3'b000, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0]  ev;
        logic [31:0] pc;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ev = 3'($urandom_range(1, 7));
            pc = $urandom;
            vec_mem[253] = $urandom;
            vec_mem[254] = $urandom;
            vec_mem[255] = $urandom;
            flow("random", ev, pc, 0, 0, 3'b000, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) vec_mem[i] = 32'hC0DE_0000 | 32'(i);
        test_reset();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_drop_midflow();
        test_reset_mid();
        test_held_through_done();
        test_random();
        n_cmp++; if (exp_epc_q.size() + exp_pc_q.size() + exp_cause_q.size() != 0) begin
            n_err++; $display("FAIL queues_drained left %0d want 0", exp_epc_q.size() + exp_pc_q.size() + exp_cause_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
